pulse_drive_seq: RTL and testbench

Parametrised multi-channel pulse-rate output drive sequencer. It generalises the fixed gyro, thrust and EMS drive logic of the interface module.
- Software loads a signed pulse count per channel.
- The block emits PLUS or MINUS pulses at the RATE strobe cadence, decrementing the count to zero.
- Sits between the channel-write decode and the external drive buffers.
- Independent mode drives all channels at once; round-robin mode drives one channel per strobe, like the gyro drive.

---
 rtl/pulse_drive_seq.sv | 157 +++++++++++++++
 tb/tb_pulse_drive_seq.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_drive_seq.sv
// Multi-channel pulse-rate drive sequencer: per-channel signed pulse counts are
// drained as PLUS/MINUS pulses on RATE strobes, in independent or round-robin mode.
module pulse_drive_seq #(
  parameter int NCH  = 4,
  parameter int CW   = 15,
  parameter int PW   = 2,
  parameter int MODE = 0,
  parameter int CHW  = $clog2(NCH)
) (
  input  logic           CLOCK,
  input  logic           rst,
  input  logic           RATE,
  input  logic           WR_EN,
  input  logic [CHW-1:0] WR_CH,
  input  logic [CW:0]    WR_DATA,
  input  logic [NCH-1:0] ENAB,
  input  logic [NCH-1:0] STOP,
  input  logic [CHW-1:0] RD_CH,
  output logic [CW:0]    RD_DATA,
  output logic [NCH-1:0] PLUS,
  output logic [NCH-1:0] MINUS,
  output logic [NCH-1:0] BUSY,
  output logic [NCH-1:0] DONE
);

  localparam int            TW     = $clog2(PW + 1);
  localparam logic [TW-1:0] PW_T   = TW'(PW);
  localparam logic [CHW:0]  NCH_W  = (CHW + 1)'(NCH);
  localparam logic [CHW:0]  LAST_W = (CHW + 1)'(NCH - 1);

  logic [CW-1:0]  cnt_q   [NCH];
  logic [CW-1:0]  cnt_d   [NCH];
  logic [TW-1:0]  timer_q [NCH];
  logic [TW-1:0]  timer_d [NCH];
  logic [NCH-1:0] sign_q, sign_d;
  logic [NCH-1:0] plus_q, plus_d;
  logic [NCH-1:0] minus_q, minus_d;
  logic [NCH-1:0] fin_q, fin_d;
  logic [NCH-1:0] done_q, done_d;
  logic [CHW-1:0] rr_q, rr_d;

  logic [NCH-1:0] load, elig, serve;

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin : eligibility
    load = '0;
    elig = '0;
    for (int i = 0; i < NCH; i++) begin
      load[i] = WR_EN && (WR_CH == CHW'(i));
      elig[i] = RATE && (cnt_q[i] != '0) && ENAB[i] && !STOP[i] &&
                (timer_q[i] == '0) && !load[i];
    end
  end

  always_comb begin : arbiter
    logic [CHW:0] pos;
    logic         found;
    serve = '0;
    rr_d  = rr_q;
    found = 1'b0;
    pos   = '0;
    if (MODE == 0) begin
      serve = elig;
    end else begin
      // Scan from the round-robin pointer with wrap; first eligible channel wins.
      for (int j = 0; j < NCH; j++) begin
        pos = {1'b0, rr_q} + (CHW + 1)'(j);
        if (pos >= NCH_W) pos = pos - NCH_W;
        if (!found && elig[pos[CHW-1:0]]) begin
          found                = 1'b1;
          serve[pos[CHW-1:0]]  = 1'b1;
          rr_d                 = (pos == LAST_W) ? '0 : pos[CHW-1:0] + CHW'(1);
        end
      end
    end
  end

  always_comb begin : channel_next
    cnt_d   = cnt_q;
    timer_d = timer_q;
    sign_d  = sign_q;
    plus_d  = plus_q;
    minus_d = minus_q;
    fin_d   = fin_q;
    done_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (timer_q[i] != '0) begin
        timer_d[i] = timer_q[i] - TW'(1);
        if (timer_q[i] == TW'(1)) begin
          plus_d[i]  = 1'b0;
          minus_d[i] = 1'b0;
          done_d[i]  = fin_q[i];
          fin_d[i]   = 1'b0;
        end
      end
      // The pulse latches the sign at service time, so a later load cannot flip it.
      if (serve[i]) begin
        cnt_d[i]   = cnt_q[i] - CW'(1);
        timer_d[i] = PW_T;
        plus_d[i]  = !sign_q[i];
        minus_d[i] = sign_q[i];
        fin_d[i]   = (cnt_q[i] == CW'(1));
      end
      // An abort or reload before the final pulse ends cancels the pending DONE.
      if (STOP[i]) begin
        cnt_d[i]  = '0;
        fin_d[i]  = 1'b0;
        done_d[i] = 1'b0;
      end else if (load[i]) begin
        cnt_d[i]  = WR_DATA[CW-1:0];
        sign_d[i] = WR_DATA[CW];
        fin_d[i]  = 1'b0;
        done_d[i] = 1'b0;
      end
    end
  end

  // NOTE: the per-channel arrays are reset explicitly because counts must read back as zero after reset.
  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]   <= '0;
        timer_q[i] <= '0;
      end
      sign_q  <= '0;
      plus_q  <= '0;
      minus_q <= '0;
      fin_q   <= '0;
      done_q  <= '0;
      rr_q    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      sign_q  <= sign_d;
      plus_q  <= plus_d;
      minus_q <= minus_d;
      fin_q   <= fin_d;
      done_q  <= done_d;
      rr_q    <= rr_d;
    end
  end

  assign PLUS  = plus_q;
  assign MINUS = minus_q;
  assign DONE  = done_q;

  always_comb begin : status
    BUSY    = '0;
    RD_DATA = '0;
    for (int i = 0; i < NCH; i++) begin
      BUSY[i] = (cnt_q[i] != '0) || (timer_q[i] != '0);
    end
    if ({1'b0, RD_CH} < NCH_W) RD_DATA = {sign_q[RD_CH], cnt_q[RD_CH]};
  end

endmodule

// File: tb/tb_pulse_drive_seq.sv
// Bench for pulse_drive_seq: an independent-mode and a round-robin instance share
// stimulus and are compared against an event-time reference model.
module tb_pulse_drive_seq;

  logic        CLOCK = 1'b0;
  logic        rst   = 1'b1;
  logic        rate  = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [1:0]  rd_ch = '0;
  logic [15:0] wr_data = '0;
  logic [3:0]  enab = '1;
  logic [3:0]  stop = '0;
  logic [15:0] rd0;
  logic [4:0]  rd1;
  logic [3:0]  plus0, minus0, busy0, done0;
  logic [3:0]  plus1, minus1, busy1, done1;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK = ~CLOCK;

  pulse_drive_seq #(.NCH(4), .CW(15), .PW(2), .MODE(0)) u_ind (
    .CLOCK(CLOCK), .rst(rst), .RATE(rate), .WR_EN(wr_en), .WR_CH(wr_ch),
    .WR_DATA(wr_data), .ENAB(enab), .STOP(stop), .RD_CH(rd_ch), .RD_DATA(rd0),
    .PLUS(plus0), .MINUS(minus0), .BUSY(busy0), .DONE(done0)
  );

  pulse_drive_seq #(.NCH(4), .CW(4), .PW(4), .MODE(1)) u_rr (
    .CLOCK(CLOCK), .rst(rst), .RATE(rate), .WR_EN(wr_en), .WR_CH(wr_ch),
    .WR_DATA({wr_data[15], wr_data[3:0]}), .ENAB(enab), .STOP(stop), .RD_CH(rd_ch),
    .RD_DATA(rd1), .PLUS(plus1), .MINUS(minus1), .BUSY(busy1), .DONE(done1)
  );

  // Reference model: each pulse is tracked by the edge number at which it ends.
  int ecnt = 0;
  int m_cnt   [2][4];
  bit m_sign  [2][4];
  int m_pend  [2][4];
  bit m_psign [2][4];
  bit m_fin   [2][4];
  bit m_done  [2][4];
  int m_rr    [2];

  function automatic int pw_of(input int p);
    return (p == 0) ? 2 : 4;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_rr[p] = 0;
      for (int i = 0; i < 4; i++) begin
        m_cnt[p][i] = 0; m_sign[p][i] = 0; m_pend[p][i] = ecnt;
        m_psign[p][i] = 0; m_fin[p][i] = 0; m_done[p][i] = 0;
      end
    end
  endtask

  task automatic model_serve(input int p, input int i);
    m_cnt[p][i]   = m_cnt[p][i] - 1;
    m_pend[p][i]  = ecnt + pw_of(p);
    m_psign[p][i] = m_sign[p][i];
    m_fin[p][i]   = (m_cnt[p][i] == 0);
  endtask

  task automatic model_edge();
    bit elig [4];
    bit found;
    int c;
    ecnt++;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        elig[i] = rate && (m_cnt[p][i] > 0) && enab[i] && !stop[i] &&
                  (ecnt > m_pend[p][i]) && !(wr_en && int'(wr_ch) == i);
        m_done[p][i] = m_fin[p][i] && (ecnt == m_pend[p][i]);
        if (m_done[p][i]) m_fin[p][i] = 0;
      end
      if (p == 0) begin
        for (int i = 0; i < 4; i++) if (elig[i]) model_serve(p, i);
      end else begin
        found = 0;
        for (int j = 0; j < 4; j++) begin
          c = (m_rr[p] + j) % 4;
          if (!found && elig[c]) begin
            found = 1;
            model_serve(p, c);
            m_rr[p] = (c + 1) % 4;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (stop[i]) begin
          m_cnt[p][i] = 0; m_fin[p][i] = 0; m_done[p][i] = 0;
        end else if (wr_en && int'(wr_ch) == i) begin
          m_cnt[p][i]  = (p == 0) ? int'(wr_data[14:0]) : int'(wr_data[3:0]);
          m_sign[p][i] = wr_data[15];
          m_fin[p][i]  = 0; m_done[p][i] = 0;
        end
      end
    end
  endtask

  function automatic logic [15:0] exp_out(input int p);
    logic [15:0] v;
    bit act;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      act       = (ecnt < m_pend[p][i]);
      v[12 + i] = act && !m_psign[p][i];
      v[8 + i]  = act && m_psign[p][i];
      v[4 + i]  = (m_cnt[p][i] != 0) || act;
      v[i]      = m_done[p][i];
    end
    return v;
  endfunction

  function automatic logic [15:0] got_out(input int p);
    return (p == 0) ? {plus0, minus0, busy0, done0} : {plus1, minus1, busy1, done1};
  endfunction

  function automatic logic [15:0] exp_rd(input int p);
    int c;
    int v;
    c = int'(rd_ch);
    v = m_cnt[p][c];
    if (p == 0) return {m_sign[0][c], v[14:0]};
    return {11'b0, m_sign[1][c], v[3:0]};
  endfunction

  function automatic logic [15:0] got_rd(input int p);
    return (p == 0) ? rd0 : {11'b0, rd1};
  endfunction

  task automatic tick();
    @(posedge CLOCK);
    model_edge();
    @(negedge CLOCK);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    rst = 1'b1;
  endtask

  task automatic drive_load(input int ch, input logic [15:0] d);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    checks++;
    if (got_out(0) !== 16'h0 || rd0 !== 16'h0) begin
      $display("FAIL reset_ind: out=%h rd=%h expected 0", got_out(0), rd0); errors++;
    end
    checks++;
    if (got_out(1) !== 16'h0 || rd1 !== 5'h0) begin
      $display("FAIL reset_rr: out=%h rd=%h expected 0", got_out(1), rd1); errors++;
    end
    model_reset();
    @(negedge CLOCK);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int plus_cycles = 0, dones = 0, done_k = -1;
    do_reset();
    rd_ch = 2'd0;
    drive_load(0, 16'h0003);
    for (int k = 0; k < 35; k++) begin
      rate = (k % 10 == 0);
      tick();
      rate = 1'b0;
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (got_out(p) !== exp_out(p) || got_rd(p) !== exp_rd(p)) begin
          $display("FAIL basic inst%0d k%0d: out=%h rd=%h expected out=%h rd=%h",
                   p, k, got_out(p), got_rd(p), exp_out(p), exp_rd(p)); errors++;
        end
      end
      if (k % 10 == 0) begin
        checks++;
        if (rd0 !== 16'((k / 10 < 3) ? 2 - k / 10 : 0)) begin
          $display("FAIL basic_count k%0d: rd=%0d expected %0d", k, rd0, (k / 10 < 3) ? 2 - k / 10 : 0);
          errors++;
        end
      end
      plus_cycles += int'(plus0[0]);
      dones       += int'(done0[0]);
      if (done0[0] && done_k < 0) done_k = k;
    end
    checks++;
    if (plus_cycles != 6 || dones != 1 || done_k != 22) begin
      $display("FAIL basic_summary: plus_cycles=%0d dones=%0d done_k=%0d expected 6 1 22",
               plus_cycles, dones, done_k); errors++;
    end
    drive_load(0, 16'h0003);
    rate = 1'b1;
    tick();
    rate = 1'b0;
    checks++;
    if (plus0[0] !== 1'b1) begin
      $display("FAIL basic_prereset_pulse: plus0=%b expected 1", plus0[0]); errors++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (got_out(0) !== 16'h0 || got_out(1) !== 16'h0 || rd0 !== 16'h0) begin
      $display("FAIL midpulse_reset: ind=%h rr=%h rd=%h expected 0", got_out(0), got_out(1), rd0);
      errors++;
    end
    model_reset();
    #1 rst = 1'b1;
  endtask

  task automatic test_concurrent();
    int d1 = -1, d2 = -1;
    do_reset();
    drive_load(1, 16'h8002);
    drive_load(2, 16'h0001);
    for (int k = 0; k < 30; k++) begin
      rate = (k == 0 || k == 10);
      tick();
      rate = 1'b0;
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (got_out(p) !== exp_out(p)) begin
          $display("FAIL concurrent inst%0d k%0d: out=%h expected %h", p, k, got_out(p), exp_out(p));
          errors++;
        end
      end
      if (k == 0 || k == 10) begin
        checks++;
        if ({plus0, minus0} !== ((k == 0) ? 8'b0100_0010 : 8'b0000_0010)) begin
          $display("FAIL concurrent_pulses k%0d: plus=%b minus=%b", k, plus0, minus0); errors++;
        end
      end
      if (done0[1] && d1 < 0) d1 = k;
      if (done0[2] && d2 < 0) d2 = k;
    end
    checks++;
    if (d2 < 0 || d1 <= d2) begin
      $display("FAIL concurrent_done_order: done2 at %0d done1 at %0d expected done2 first", d2, d1);
      errors++;
    end
  endtask

  task automatic test_round_robin();
    int order [$];
    int exp_order [6] = '{0, 1, 3, 0, 1, 3};
    logic [3:0] prev = '0;
    bit ch2_seen = 0;
    do_reset();
    drive_load(0, 16'h0002);
    drive_load(1, 16'h0002);
    drive_load(2, 16'h0000);
    drive_load(3, 16'h0002);
    for (int k = 0; k < 56; k++) begin
      rate = (k % 8 == 0) && (k < 48);
      tick();
      rate = 1'b0;
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (got_out(p) !== exp_out(p)) begin
          $display("FAIL rr inst%0d k%0d: out=%h expected %h", p, k, got_out(p), exp_out(p)); errors++;
        end
      end
      for (int i = 0; i < 4; i++) if (plus1[i] && !prev[i]) order.push_back(i);
      if (plus1[2] || plus0[2]) ch2_seen = 1;
      prev = plus1;
    end
    checks++;
    if (order.size() != 6 || ch2_seen) begin
      $display("FAIL rr_count: served=%0d ch2_pulsed=%0d expected 6 0", order.size(), ch2_seen);
      errors++;
    end else begin
      for (int n = 0; n < 6; n++) begin
        checks++;
        if (order[n] != exp_order[n]) begin
          $display("FAIL rr_order slot%0d: ch%0d expected ch%0d", n, order[n], exp_order[n]); errors++;
        end
      end
    end
    for (int i = 0; i < 4; i++) drive_load(i, 16'h0001);
    rate = 1'b1;
    tick();
    rate = 1'b0;
    checks++;
    if (plus1 !== 4'b0001 || got_out(1) !== exp_out(1)) begin
      $display("FAIL rr_pointer_wrap: plus=%b expected 0001", plus1); errors++;
    end
  endtask

  task automatic test_enable_stop();
    int pulses = 0, dones = 0;
    do_reset();
    rd_ch = 2'd0;
    enab[0] = 1'b0;
    drive_load(0, 16'h0005);
    for (int k = 0; k < 18; k++) begin
      rate = (k % 6 == 0);
      tick();
      rate = 1'b0;
      pulses += int'(plus0[0] | plus1[0]);
    end
    checks++;
    if (pulses != 0 || rd0 !== 16'd5 || rd1 !== 5'd5) begin
      $display("FAIL enab_hold: pulses=%0d rd=%0d/%0d expected 0 5/5", pulses, rd0, rd1); errors++;
    end
    enab[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rate = (k % 6 == 0);
      tick();
      rate = 1'b0;
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (got_out(p) !== exp_out(p) || got_rd(p) !== exp_rd(p)) begin
          $display("FAIL enable inst%0d k%0d: out=%h rd=%h expected out=%h rd=%h",
                   p, k, got_out(p), got_rd(p), exp_out(p), exp_rd(p)); errors++;
        end
      end
    end
    checks++;
    if (rd0 !== 16'd3) begin
      $display("FAIL enable_count: rd=%0d expected 3", rd0); errors++;
    end
    rate = 1'b1;
    tick();
    rate = 1'b0;
    stop[0] = 1'b1;
    tick();
    stop[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (got_out(p) !== exp_out(p)) begin
          $display("FAIL stop inst%0d k%0d: out=%h expected %h", p, k, got_out(p), exp_out(p)); errors++;
        end
      end
      dones += int'(done0[0] | done1[0]);
      tick();
    end
    checks++;
    if (dones != 0 || busy0[0] !== 1'b0 || busy1[0] !== 1'b0 || rd0 !== 16'd0) begin
      $display("FAIL stop_final: dones=%0d busy=%b%b rd=%0d expected 0 00 0", dones, busy0[0], busy1[0], rd0);
      errors++;
    end
  endtask

  task automatic test_collision();
    int minus_edges = 0, plus_cycles = 0;
    logic prev = 1'b0;
    do_reset();
    rd_ch = 2'd0;
    drive_load(0, 16'h0004);
    wr_en = 1'b1; wr_ch = 2'd0; wr_data = 16'h8007; rate = 1'b1;
    tick();
    wr_en = 1'b0; rate = 1'b0;
    checks++;
    if (rd0 !== 16'h8007 || rd1 !== 5'b10111 || (plus0[0] | minus0[0] | plus1[0] | minus1[0]) !== 1'b0) begin
      $display("FAIL collision_load: rd=%h/%h pulse=%b%b expected 8007/17 no pulse", rd0, rd1, plus0[0], minus0[0]);
      errors++;
    end
    for (int k = 0; k < 18; k++) begin
      rate = (k % 6 == 0);
      tick();
      rate = 1'b0;
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (got_out(p) !== exp_out(p) || got_rd(p) !== exp_rd(p)) begin
          $display("FAIL collision inst%0d k%0d: out=%h rd=%h expected out=%h rd=%h",
                   p, k, got_out(p), got_rd(p), exp_out(p), exp_rd(p)); errors++;
        end
      end
      if (minus0[0] && !prev) minus_edges++;
      plus_cycles += int'(plus0[0]);
      prev = minus0[0];
    end
    checks++;
    if (minus_edges != 3 || plus_cycles != 0 || rd0 !== 16'h8004) begin
      $display("FAIL collision_drain: minus=%0d plus=%0d rd=%h expected 3 0 8004", minus_edges, plus_cycles, rd0);
      errors++;
    end
  endtask

  task automatic test_fast_rate();
    int edges0 = 0, edges1 = 0, dones1 = 0;
    logic prev0 = 1'b0, prev1 = 1'b0;
    do_reset();
    drive_load(0, 16'h0003);
    for (int k = 0; k < 40; k++) begin
      rate = (k % 2 == 0);
      tick();
      rate = 1'b0;
      checks++;
      if (got_out(1) !== exp_out(1)) begin
        $display("FAIL fast_rate k%0d: out=%h expected %h", k, got_out(1), exp_out(1)); errors++;
      end
      if (plus1[0] && !prev1) edges1++;
      dones1 += int'(done1[0]);
      prev1 = plus1[0];
    end
    checks++;
    if (edges1 != 3 || dones1 != 1) begin
      $display("FAIL fast_rate_total: pulses=%0d dones=%0d expected 3 1", edges1, dones1); errors++;
    end
    drive_load(0, 16'h000F);
    edges1 = 0;
    prev1 = 1'b0;
    rate = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (got_out(p) !== exp_out(p)) begin
          $display("FAIL max_count inst%0d k%0d: out=%h expected %h", p, k, got_out(p), exp_out(p)); errors++;
        end
      end
      if (plus0[0] && !prev0) edges0++;
      if (plus1[0] && !prev1) edges1++;
      prev0 = plus0[0];
      prev1 = plus1[0];
    end
    rate = 1'b0;
    checks++;
    if (edges0 != 15 || edges1 != 15) begin
      $display("FAIL max_count_total: pulses=%0d/%0d expected 15/15", edges0, edges1); errors++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      rate    = ($urandom_range(0, 2) == 0);
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_ch   = 2'($urandom_range(0, 3));
      wr_data = {1'($urandom_range(0, 1)), 11'b0, 4'($urandom_range(0, 6))};
      rd_ch   = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) begin
        enab[i] = ($urandom_range(0, 7) != 0);
        stop[i] = ($urandom_range(0, 39) == 0);
      end
      tick();
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (got_out(p) !== exp_out(p) || got_rd(p) !== exp_rd(p)) begin
          $display("FAIL random inst%0d k%0d: out=%h rd=%h expected out=%h rd=%h",
                   p, k, got_out(p), got_rd(p), exp_out(p), exp_rd(p)); errors++;
        end
      end
    end
    rate = 1'b0; wr_en = 1'b0; enab = '1; stop = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_concurrent();
    test_round_robin();
    test_enable_stop();
    test_collision();
    test_fast_rate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
